// File: rtl/flipflop_d_neg_clk_neg_rst_with_neg_load_enable_pkg.sv
// flipflop_pkg: shared default width and reset value for the falling-edge D flip-flop
package flipflop_pkg;
  localparam int DEFAULT_WIDTH = 1;
  localparam logic [63:0] DEFAULT_RESET_VALUE = '0;
endpackage

// File: rtl/flipflop_d_neg_clk_neg_rst_with_neg_load_enable_if.sv
// flipflop_d_neg_clk_neg_rst_with_neg_load_enable_if: data/enable in, Q/Qn (and optional Changed) out
interface flipflop_d_neg_clk_neg_rst_with_neg_load_enable_if
  import flipflop_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] D;
  logic             Enbar;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Qn;
`ifdef FLIPFLOP_CHANGE_FLAG_EN
  logic             Changed;
  modport master (output D, Enbar, input Q, Qn, Changed);
  modport slave (input D, Enbar, output Q, Qn, Changed);
`else
  modport master (output D, Enbar, input Q, Qn);
  modport slave (input D, Enbar, output Q, Qn);
`endif
endinterface

// File: rtl/flipflop_d_neg_clk_neg_rst_with_neg_load_enable_bit_cell.sv
// flipflop_bit_cell: 1-bit falling-edge cell, sync active-high clear, active-low load enable
module flipflop_bit_cell #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic ClkN,
  input  logic ClrN,
  input  logic d_i,
  input  logic enbar_i,
  output logic q_o
);
  logic q_q, q_d;
  always_comb q_d = enbar_i ? q_q : d_i;
  always_ff @(negedge ClkN) q_q <= ClrN ? RESET_VALUE : q_d;
  assign q_o = q_q;
endmodule

// File: rtl/flipflop_d_neg_clk_neg_rst_with_neg_load_enable.sv
// flipflop_d_neg_clk_neg_rst_with_neg_load_enable: WIDTH-bit falling-edge D register; FLIPFLOP_CHANGE_FLAG_EN adds Changed
module flipflop_d_neg_clk_neg_rst_with_neg_load_enable
  import flipflop_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input logic ClkN,
  input logic ClrN,
  flipflop_d_neg_clk_neg_rst_with_neg_load_enable_if.slave bus
);
  logic [WIDTH-1:0] q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    flipflop_bit_cell #(.RESET_VALUE(RESET_VALUE[i])) u_cell (
      .ClkN    (ClkN),
      .ClrN    (ClrN),
      .d_i     (bus.D[i]),
      .enbar_i (bus.Enbar),
      .q_o     (q[i])
    );
  end
  assign bus.Q  = q;
  assign bus.Qn = ~q;
`ifdef FLIPFLOP_CHANGE_FLAG_EN
  logic changed_q, changed_d;
  // a hold can never change Q, so only a load of a different value raises the flag
  always_comb changed_d = ~bus.Enbar & (bus.D != q);
  always_ff @(negedge ClkN) changed_q <= ClrN ? 1'b0 : changed_d;
  assign bus.Changed = changed_q;
`endif
endmodule

// File: tb/tb_flipflop_d_neg_clk_neg_rst_with_neg_load_enable.sv
// tb_flipflop_d_neg_clk_neg_rst_with_neg_load_enable: directed checks on WIDTH=1 and WIDTH=8 instances
module tb_flipflop_d_neg_clk_neg_rst_with_neg_load_enable;
  logic ClkN = 1'b1;
  logic clr1, clr8;
  int checks = 0;
  int errors = 0;
  always #10 ClkN = ~ClkN;
  flipflop_d_neg_clk_neg_rst_with_neg_load_enable_if #(.WIDTH(1)) bus1 ();
  flipflop_d_neg_clk_neg_rst_with_neg_load_enable_if #(.WIDTH(8)) bus8 ();
  flipflop_d_neg_clk_neg_rst_with_neg_load_enable #(.WIDTH(1), .RESET_VALUE(1'b0)) u_dut1 (
    .ClkN (ClkN),
    .ClrN (clr1),
    .bus  (bus1)
  );
  flipflop_d_neg_clk_neg_rst_with_neg_load_enable #(.WIDTH(8), .RESET_VALUE(8'h3C)) u_dut8 (
    .ClkN (ClkN),
    .ClrN (clr8),
    .bus  (bus8)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic edge_n();
    @(negedge ClkN);
    #5;
  endtask
  initial begin
    clr1 = 1'b1; bus1.Enbar = 1'b0; bus1.D = 1'b1;
    clr8 = 1'b1; bus8.Enbar = 1'b0; bus8.D = 8'hA5;
    edge_n();
    chk("rst1_q_e1", 8'(bus1.Q), 8'h00);
    chk("rst1_qn_e1", 8'(bus1.Qn), 8'h01);
    chk("rst8_q", bus8.Q, 8'h3C);
    chk("rst8_qn", bus8.Qn, 8'hC3);
`ifdef FLIPFLOP_CHANGE_FLAG_EN
    chk("rst8_changed", 8'(bus8.Changed), 8'h00);
`endif
    edge_n();
    chk("rst1_q_e2", 8'(bus1.Q), 8'h00);
    chk("rst1_qn_e2", 8'(bus1.Qn), 8'h01);
    edge_n();
    chk("rst1_q_e3", 8'(bus1.Q), 8'h00);
    chk("rst1_qn_e3", 8'(bus1.Qn), 8'h01);
    clr1 = 1'b0; bus1.Enbar = 1'b1; bus1.D = 1'b1;
    clr8 = 1'b0;
    edge_n();
    chk("hold1_e1", 8'(bus1.Q), 8'h00);
    chk("load8_q", bus8.Q, 8'hA5);
    chk("load8_qn", bus8.Qn, 8'h5A);
`ifdef FLIPFLOP_CHANGE_FLAG_EN
    chk("chg8_first", 8'(bus8.Changed), 8'h01);
`endif
    edge_n();
    chk("hold1_e2", 8'(bus1.Q), 8'h00);
    chk("load8_again", bus8.Q, 8'hA5);
`ifdef FLIPFLOP_CHANGE_FLAG_EN
    chk("chg8_second", 8'(bus8.Changed), 8'h00);
`endif
    clr8 = 1'b1;
    edge_n();
    chk("hold1_e3", 8'(bus1.Q), 8'h00);
    chk("rst8_prio_q", bus8.Q, 8'h3C);
    chk("rst8_prio_qn", bus8.Qn, 8'hC3);
`ifdef FLIPFLOP_CHANGE_FLAG_EN
    chk("chg8_rst", 8'(bus8.Changed), 8'h00);
`endif
    bus1.Enbar = 1'b0; bus1.D = 1'b1;
    clr8 = 1'b0; bus8.Enbar = 1'b1; bus8.D = 8'hFF;
    @(posedge ClkN);
    #1;
    chk("rise_no_effect", 8'(bus1.Q), 8'h00);
    edge_n();
    chk("load1_q", 8'(bus1.Q), 8'h01);
    chk("load1_qn", 8'(bus1.Qn), 8'h00);
    bus1.D = 1'b0;
    #2 bus1.D = 1'b1;
    #2;
    chk("no_glitch", 8'(bus1.Q), 8'h01);
    @(posedge ClkN);
    #5 bus1.D = 1'b0;
    edge_n();
    chk("load0_q", 8'(bus1.Q), 8'h00);
    chk("load0_qn", 8'(bus1.Qn), 8'h01);
    bus1.D = 1'b1;
    edge_n();
    chk("reload1_q", 8'(bus1.Q), 8'h01);
    clr1 = 1'b1;
    #2;
    chk("no_async_clr", 8'(bus1.Q), 8'h01);
    @(posedge ClkN);
    #1;
    chk("no_clr_on_rise", 8'(bus1.Q), 8'h01);
    edge_n();
    chk("sync_clr_q", 8'(bus1.Q), 8'h00);
    chk("hold8_q", bus8.Q, 8'h3C);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
